// File: rtl/metadata_server.sv
// -----------------------------------------------------------------------------
// metadata_server
//   Responder end of the per-channel note-metadata interface. Words arrive from
//   the song loader tagged with a channel number and are buffered in a 2-entry
//   FIFO per channel. Each channel's head word is presented on metadata_link
//   with metadata_available and is retired when the scoring block pulses that
//   channel's metadata_request bit.
//
//   Optional feature macro: METADATA_UNDERRUN_CNT_EN
//     defined   : underrun_count counts requests to empty channels (saturating)
//     undefined : no underrun logic, underrun_count tied to zero
//
// Ports
//   clk                 system clock
//   reset_n             synchronous active-low reset
//   flush               song restart, empties every channel buffer
//   pause               masks all metadata_request bits while high
//   in_valid            loader presents a word
//   in_channel [CW]     target channel of the word
//   in_word    [W]      metadata word
//   in_ready            word accepted when in_valid & in_ready
//   metadata_request[NCH]  per-channel pop pulse
//   metadata_link[NCH*W]   channel i head word at [i*W +: W]
//   metadata_available[NCH] channel i head word valid
//   served_count [16]   total words retired, wraps
//   underrun_count [8]  requests seen on empty channels, saturating
// -----------------------------------------------------------------------------
module metadata_server #(
  parameter int NCH = 37,
  parameter int W   = 16,
  parameter int CW  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               pause,
  input  logic               in_valid,
  input  logic [CW-1:0]      in_channel,
  input  logic [W-1:0]       in_word,
  output logic               in_ready,
  input  logic [NCH-1:0]     metadata_request,
  output logic [NCH*W-1:0]   metadata_link,
  output logic [NCH-1:0]     metadata_available,
  output logic [15:0]        served_count,
  output logic [7:0]         underrun_count
);

  logic [NCH-1:0][W-1:0] head_q, head_d;
  logic [NCH-1:0][W-1:0] tail_q, tail_d;
  logic [NCH-1:0][1:0]   cnt_q,  cnt_d;
  logic [15:0]           served_q, served_d;
  logic [15:0]           npop;

  logic                  ch_valid;
  logic                  sel_full;
  logic                  push;
  logic [NCH-1:0]        push_sel;
  logic [NCH-1:0]        req;

  // Extra bit on the compare so a channel count equal to 2^CW cannot wrap.
  always_comb begin
    ch_valid = ({1'b0, in_channel} < (CW+1)'(NCH));
    sel_full = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_channel == CW'(i)) sel_full = (cnt_q[i] == 2'd2);
    end
    in_ready = reset_n & ~flush & (~ch_valid | ~sel_full);
  end

  // Out-of-range channels are acknowledged but never stored.
  assign push = in_valid & in_ready & ch_valid;
  assign req  = metadata_request & {NCH{~pause & ~flush}};

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      push_sel[i] = push && (in_channel == CW'(i));
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    npop   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (cnt_q[i])
        2'd0: begin
          if (push_sel[i]) begin
            head_d[i] = in_word;
            cnt_d[i]  = 2'd1;
          end
        end
        2'd1: begin
          if (req[i]) begin
            npop = npop + 16'd1;
            // Push during a pop of the only word lands straight in head.
            if (push_sel[i]) head_d[i] = in_word;
            else             cnt_d[i]  = 2'd0;
          end else if (push_sel[i]) begin
            tail_d[i] = in_word;
            cnt_d[i]  = 2'd2;
          end
        end
        default: begin
          // Full: in_ready already blocked any push to this channel.
          if (req[i]) begin
            npop      = npop + 16'd1;
            head_d[i] = tail_q[i];
            cnt_d[i]  = 2'd1;
          end
        end
      endcase
    end
    if (flush) begin
      head_d = '0;
      cnt_d  = '0;
    end
    served_d = served_q + npop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      served_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
    end
  end

  assign metadata_link = head_q;
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      metadata_available[i] = (cnt_q[i] != 2'd0);
    end
  end
  assign served_count = served_q;

`ifdef METADATA_UNDERRUN_CNT_EN
  logic [7:0]  under_q, under_d;
  logic [15:0] nund;
  logic [16:0] usum;

  always_comb begin
    nund = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[i] && (cnt_q[i] == 2'd0)) nund = nund + 16'd1;
    end
    usum    = {9'd0, under_q} + {1'b0, nund};
    under_d = (usum > 17'd255) ? 8'hFF : usum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) under_q <= '0;
    else          under_q <= under_d;
  end

  assign underrun_count = under_q;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_metadata_server.sv
// -----------------------------------------------------------------------------
// tb_metadata_server
//   Directed bench for metadata_server. Expected values are queued as the
//   stimulus is driven and compared against the DUT outputs when drained.
// -----------------------------------------------------------------------------
module tb_metadata_server;

  localparam int NCH = 37;
  localparam int W   = 16;
  localparam int CW  = 6;
`ifdef METADATA_UNDERRUN_CNT_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              pause;
  logic              in_valid;
  logic [CW-1:0]     in_channel;
  logic [W-1:0]      in_word;
  logic              in_ready;
  logic [NCH-1:0]    metadata_request;
  logic [NCH*W-1:0]  metadata_link;
  logic [NCH-1:0]    metadata_available;
  logic [15:0]       served_count;
  logic [7:0]        underrun_count;

  metadata_server #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .flush              (flush),
    .pause              (pause),
    .in_valid           (in_valid),
    .in_channel         (in_channel),
    .in_word            (in_word),
    .in_ready           (in_ready),
    .metadata_request   (metadata_request),
    .metadata_link      (metadata_link),
    .metadata_available (metadata_available),
    .served_count       (served_count),
    .underrun_count     (underrun_count)
  );

  always #5 clk = ~clk;

  // kinds: 0 avail bit, 1 link slice, 2 served, 3 underrun, 4 in_ready,
  //        5 avail vector, 6 link-is-zero flag
  typedef struct {
    string       tag;
    int          kind;
    int          ch;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [63:0] observe(input int kind, input int ch);
    case (kind)
      0:       return 64'(metadata_available[ch]);
      1:       return 64'(metadata_link[ch*W +: W]);
      2:       return 64'(served_count);
      3:       return 64'(underrun_count);
      4:       return 64'(in_ready);
      5:       return 64'(metadata_available);
      default: return 64'(metadata_link == '0);
    endcase
  endfunction

  function automatic logic [63:0] uexp(input int n);
    return UEN ? 64'(n) : 64'd0;
  endfunction

  task automatic chk(input string tag, input int kind, input int ch, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.ch = ch; e.val = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.kind, e.ch);
      n_cmp++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; pause = 1'b0;
    in_valid = 1'b1; in_channel = 6'd5; in_word = 16'hFFFF;
    metadata_request = '0;

    // Reset held two cycles with a word offered
    tick(); tick();
    chk("rst_avail", 5, 0, 64'd0);
    chk("rst_link_zero", 6, 0, 64'd1);
    chk("rst_served", 2, 0, 64'd0);
    chk("rst_under", 3, 0, 64'd0);
    chk("rst_in_ready", 4, 0, 64'd0);
    drain();
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 4, 0, 64'd1);
    drain();

    // Fill and drain channel 5
    in_valid = 1'b1; in_channel = 6'd5; in_word = 16'hA001;
    tick();
    in_word = 16'hA002;
    tick();
    in_word = 16'hA003;
    #1;
    chk("fill_avail5", 0, 5, 64'd1);
    chk("fill_link5", 1, 5, 64'hA001);
    chk("full_in_ready", 4, 0, 64'd0);
    drain();
    in_valid = 1'b0;
    metadata_request[5] = 1'b1;
    tick();
    metadata_request = '0;
    chk("pop2_link5", 1, 5, 64'hA002);
    chk("pop2_avail5", 0, 5, 64'd1);
    chk("pop2_served", 2, 0, 64'd1);
    drain();
    metadata_request[5] = 1'b1;
    tick();
    metadata_request = '0;
    chk("pop1_avail5", 0, 5, 64'd0);
    chk("pop1_stale_link5", 1, 5, 64'hA002);
    chk("pop1_served", 2, 0, 64'd2);
    drain();

    // Simultaneous push and pop on ch0 holding one word
    in_valid = 1'b1; in_channel = 6'd0; in_word = 16'h1111;
    tick();
    in_word = 16'h2222;
    metadata_request[0] = 1'b1;
    #1;
    chk("sim_in_ready", 4, 0, 64'd1);
    drain();
    tick();
    in_valid = 1'b0; metadata_request = '0;
    chk("sim_link0", 1, 0, 64'h2222);
    chk("sim_avail0", 0, 0, 64'd1);
    chk("sim_served", 2, 0, 64'd3);
    drain();
    metadata_request[0] = 1'b1;
    tick();
    metadata_request = '0;
    chk("ch0_empty", 0, 0, 64'd0);
    chk("ch0_served", 2, 0, 64'd4);
    drain();

    // Underrun on empty ch36
    metadata_request[36] = 1'b1;
    tick();
    metadata_request = '0;
    chk("under_one", 3, 0, uexp(1));
    chk("under_served", 2, 0, 64'd4);
    drain();

    // Pause on a full channel
    in_valid = 1'b1; in_channel = 6'd5; in_word = 16'hB001;
    tick();
    in_word = 16'hB002;
    tick();
    in_valid = 1'b0;
    pause = 1'b1; metadata_request[5] = 1'b1;
    tick();
    pause = 1'b0; metadata_request = '0;
    chk("pause_link5", 1, 5, 64'hB001);
    chk("pause_avail5", 0, 5, 64'd1);
    chk("pause_served", 2, 0, 64'd4);
    chk("pause_under", 3, 0, uexp(1));
    drain();

    // 300 more underruns: request held high
    metadata_request[36] = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    metadata_request = '0;
    chk("under_sat", 3, 0, uexp(255));
    chk("sat_served", 2, 0, 64'd4);
    drain();

    // Out-of-range channel
    in_valid = 1'b1; in_channel = 6'd40; in_word = 16'hDEAD;
    #1;
    chk("bad_in_ready", 4, 0, 64'd1);
    drain();
    tick();
    in_valid = 1'b0;
    chk("bad_avail_vec", 5, 0, 64'd1 << 5);
    drain();

    // Empty ch5, then fill every channel with one word and pop all at once
    metadata_request[5] = 1'b1;
    tick(); tick();
    metadata_request = '0;
    chk("ch5_drained_served", 2, 0, 64'd6);
    chk("all_empty", 5, 0, 64'd0);
    drain();
    in_valid = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      in_channel = 6'(i);
      in_word    = 16'hC000 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_all_avail", 5, 0, (64'd1 << NCH) - 64'd1);
    chk("fill_link36", 1, 36, 64'hC024);
    chk("fill_link17", 1, 17, 64'hC011);
    drain();
    metadata_request = '1;
    tick();
    metadata_request = '0;
    chk("multi_served", 2, 0, 64'd43);
    chk("multi_avail", 5, 0, 64'd0);
    chk("multi_under", 3, 0, uexp(255));
    drain();

    // Flush mid-stream
    in_valid = 1'b1; in_channel = 6'd3; in_word = 16'hD003;
    tick();
    in_word = 16'hD004;
    tick();
    in_channel = 6'd7; in_word = 16'hD007;
    tick();
    flush = 1'b1; in_channel = 6'd7; in_word = 16'hEEEE;
    metadata_request[3] = 1'b1;
    #1;
    chk("flush_in_ready", 4, 0, 64'd0);
    drain();
    tick();
    flush = 1'b0; in_valid = 1'b0; metadata_request = '0;
    chk("flush_avail", 5, 0, 64'd0);
    chk("flush_link_zero", 6, 0, 64'd1);
    chk("flush_served", 2, 0, 64'd43);
    chk("flush_under", 3, 0, uexp(255));
    drain();

    // Normal operation resumes after flush
    in_valid = 1'b1; in_channel = 6'd7; in_word = 16'hF007;
    tick();
    in_valid = 1'b0;
    chk("post_flush_link7", 1, 7, 64'hF007);
    chk("post_flush_avail", 5, 0, 64'd1 << 7);
    drain();

    // Reset mid-stream
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2_avail", 5, 0, 64'd0);
    chk("rst2_link_zero", 6, 0, 64'd1);
    chk("rst2_served", 2, 0, 64'd0);
    chk("rst2_under", 3, 0, 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
